// File: rtl/steed_pkg.sv
// rtl/steed_pkg.sv - shared types and constants for the steed command engine
// Contents: FSM state enum, ATA opcodes, Status/Error/Device Control bit indices.
package steed_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_DECODE,
    ST_RD_MEDIA,
    ST_RD_XFER,
    ST_WR_XFER,
    ST_WR_MEDIA,
    ST_DONE,
    ST_ABORT,
    ST_ERROR
  } steed_state_e;

  localparam logic [7:0] OP_READ_SECTORS  = 8'h20;
  localparam logic [7:0] OP_WRITE_SECTORS = 8'h30;
  localparam logic [7:0] OP_IDENTIFY      = 8'hEC;

  // Status register bit indices
  localparam int STS_BSY  = 7;
  localparam int STS_DRDY = 6;
  localparam int STS_DF   = 5;
  localparam int STS_DSC  = 4;
  localparam int STS_DRQ  = 3;
  localparam int STS_CORR = 2;
  localparam int STS_IDX  = 1;
  localparam int STS_ERR  = 0;

  // Error register bit indices
  localparam int ERR_UNC  = 6;
  localparam int ERR_ABRT = 2;

  // Device Control bit indices
  localparam int DC_SRST  = 2;
  localparam int DC_NIEN  = 1;

  localparam logic [7:0] STATUS_IDLE = 8'h50;  // DRDY | DSC
  localparam logic [7:0] STATUS_SRST = 8'h80;  // BSY only, held during soft reset

endpackage

// File: rtl/steed_tgl_sync.sv
// rtl/steed_tgl_sync.sv - toggle synchroniser with change detect
// Ports: clk, rst_n (async, active-low); tgl = toggle from a foreign strobe domain;
// change = one-cycle high whenever the synchronised toggle differs from its last value.
module steed_tgl_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tgl,
  output logic change
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Not cleared by soft reset: the chain tracks the external toggle level, so
  // wiping it would manufacture a phantom edge when SRST is released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], tgl};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign change = sync_q[SYNC_STAGES-1] ^ prev_q;

endmodule

// File: rtl/steed_cmd_fsm.sv
// rtl/steed_cmd_fsm.sv - ATA command execution engine (PIO read/write sequencing)
// Ports: clk, rst_n (async, active-low); reg_cmdin_tgl/rd_status = foreign-domain toggles;
// reg_command/reg_sector_count/reg_lba/reg_dev_control = task file; xfer_word = host word strobe;
// media_req/media_wr/media_lba/media_ack/media_err = back-end sector handshake;
// reg_status/reg_error = Status/Error bytes; steed_intrq = host interrupt.
// Build option: STEED_IDENTIFY_EN enables opcode 0xEC (IDENTIFY) on the read path.
module steed_cmd_fsm #(
  parameter int WORDS_PER_SECTOR = 256,
  parameter int SYNC_STAGES      = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        reg_cmdin_tgl,
  input  logic        rd_status,
  input  logic [7:0]  reg_command,
  input  logic [7:0]  reg_sector_count,
  input  logic [27:0] reg_lba,
  input  logic [7:0]  reg_dev_control,
  input  logic        xfer_word,
  input  logic        media_ack,
  input  logic        media_err,
  output logic        media_req,
  output logic        media_wr,
  output logic [27:0] media_lba,
  output logic [7:0]  reg_status,
  output logic [7:0]  reg_error,
  output logic        steed_intrq
);

  import steed_pkg::*;

  localparam int WCW = $clog2(WORDS_PER_SECTOR);

  steed_state_e   state;
  logic [7:0]     opcode_q;
  logic [8:0]     remaining;   // 1..256 sectors left, including the current one
  logic [WCW-1:0] word_cnt;
  logic           intr_pend;
  logic           cmd_new;
  logic           rd_new;
  logic           last_word;
  logic           more_sectors;
  logic           unused_dev_control;

  steed_tgl_sync #(.SYNC_STAGES(SYNC_STAGES)) u_cmd_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .tgl    (reg_cmdin_tgl),
    .change (cmd_new)
  );

  steed_tgl_sync #(.SYNC_STAGES(SYNC_STAGES)) u_rd_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .tgl    (rd_status),
    .change (rd_new)
  );

  assign last_word          = xfer_word && (word_cnt == WCW'(WORDS_PER_SECTOR - 1));
  assign more_sectors       = (remaining > 9'd1);
  assign unused_dev_control = ^{reg_dev_control[7:3], reg_dev_control[0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      opcode_q   <= '0;
      remaining  <= '0;
      word_cnt   <= '0;
      intr_pend  <= 1'b0;
      media_req  <= 1'b0;
      media_wr   <= 1'b0;
      media_lba  <= '0;
      reg_status <= STATUS_IDLE;
      reg_error  <= '0;
    end else if (reg_dev_control[DC_SRST]) begin
      state      <= ST_IDLE;
      opcode_q   <= '0;
      remaining  <= '0;
      word_cnt   <= '0;
      intr_pend  <= 1'b0;
      media_req  <= 1'b0;
      media_wr   <= 1'b0;
      media_lba  <= '0;
      reg_status <= STATUS_SRST;
      reg_error  <= '0;
    end else begin
      // A status read acknowledges the interrupt; a raise in the same cycle wins below.
      if (rd_new) intr_pend <= 1'b0;

      case (state)
        ST_IDLE: begin
          // Re-asserting the ready bits here also restores 8'h50 after a soft reset.
          reg_status[STS_BSY]  <= 1'b0;
          reg_status[STS_DRDY] <= 1'b1;
          reg_status[STS_DSC]  <= 1'b1;
          if (cmd_new) begin
            opcode_q            <= reg_command;
            media_lba           <= reg_lba;
            remaining           <= (reg_sector_count == 8'd0) ? 9'd256 : {1'b0, reg_sector_count};
            word_cnt            <= '0;
            reg_status[STS_BSY] <= 1'b1;
            reg_status[STS_ERR] <= 1'b0;
            reg_error           <= '0;
            intr_pend           <= 1'b0;
            state               <= ST_DECODE;
          end
        end

        ST_DECODE: begin
          case (opcode_q)
            OP_READ_SECTORS: begin
              media_req <= 1'b1;
              media_wr  <= 1'b0;
              state     <= ST_RD_MEDIA;
            end
            OP_WRITE_SECTORS: begin
              reg_status[STS_BSY] <= 1'b0;
              reg_status[STS_DRQ] <= 1'b1;
              state               <= ST_WR_XFER;
            end
`ifdef STEED_IDENTIFY_EN
            OP_IDENTIFY: begin
              // Data comes from the IDENTIFY buffer, so skip the media fetch.
              remaining           <= 9'd1;
              reg_status[STS_BSY] <= 1'b0;
              reg_status[STS_DRQ] <= 1'b1;
              intr_pend           <= 1'b1;
              state               <= ST_RD_XFER;
            end
`endif
            default: state <= ST_ABORT;
          endcase
        end

        ST_RD_MEDIA: begin
          if (media_ack) begin
            media_req <= 1'b0;
            if (media_err) begin
              state <= ST_ERROR;
            end else begin
              reg_status[STS_BSY] <= 1'b0;
              reg_status[STS_DRQ] <= 1'b1;
              intr_pend           <= 1'b1;
              state               <= ST_RD_XFER;
            end
          end
        end

        ST_RD_XFER: begin
          if (xfer_word) begin
            word_cnt <= word_cnt + WCW'(1);
            if (last_word) begin
              word_cnt            <= '0;
              reg_status[STS_DRQ] <= 1'b0;
              reg_status[STS_BSY] <= 1'b1;
              media_lba           <= media_lba + 28'd1;
              remaining           <= remaining - 9'd1;
              if (more_sectors) begin
                media_req <= 1'b1;
                media_wr  <= 1'b0;
                state     <= ST_RD_MEDIA;
              end else begin
                state <= ST_DONE;
              end
            end
          end
        end

        ST_WR_XFER: begin
          if (xfer_word) begin
            word_cnt <= word_cnt + WCW'(1);
            if (last_word) begin
              word_cnt            <= '0;
              reg_status[STS_DRQ] <= 1'b0;
              reg_status[STS_BSY] <= 1'b1;
              media_req           <= 1'b1;
              media_wr            <= 1'b1;
              state               <= ST_WR_MEDIA;
            end
          end
        end

        ST_WR_MEDIA: begin
          if (media_ack) begin
            media_req <= 1'b0;
            media_wr  <= 1'b0;
            if (media_err) begin
              state <= ST_ERROR;
            end else begin
              intr_pend <= 1'b1;
              if (more_sectors) begin
                media_lba           <= media_lba + 28'd1;
                remaining           <= remaining - 9'd1;
                reg_status[STS_BSY] <= 1'b0;
                reg_status[STS_DRQ] <= 1'b1;
                state               <= ST_WR_XFER;
              end else begin
                state <= ST_DONE;
              end
            end
          end
        end

        ST_DONE: begin
          reg_status[STS_BSY] <= 1'b0;
          reg_status[STS_DRQ] <= 1'b0;
          state               <= ST_IDLE;
        end

        ST_ABORT: begin
          reg_status[STS_ERR] <= 1'b1;
          reg_status[STS_BSY] <= 1'b0;
          reg_status[STS_DRQ] <= 1'b0;
          reg_error[ERR_ABRT] <= 1'b1;
          intr_pend           <= 1'b1;
          state               <= ST_IDLE;
        end

        ST_ERROR: begin
          reg_status[STS_ERR] <= 1'b1;
          reg_status[STS_BSY] <= 1'b0;
          reg_status[STS_DRQ] <= 1'b0;
          reg_error[ERR_UNC]  <= 1'b1;
          intr_pend           <= 1'b1;
          state               <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  assign steed_intrq = intr_pend & ~reg_dev_control[DC_NIEN];

endmodule
